// File: rtl/clk_ratio_meter_if.sv
// ----------------------------------------------------------------------------
// clk_ratio_meter_if
//   Signal bundle between a divided-clock source / result consumer (master)
//   and the clk_ratio_meter (slave).
//
//   div_i      master->slave  divided clock under test (asynchronous)
//   en_i       master->slave  measurement enable
//   period_o   slave->master  last measured period, in clk_i cycles
//   high_o     slave->master  last measured high time (duty build only)
//   valid_o    slave->master  one-cycle pulse when period_o/high_o update
//   locked_o   slave->master  run of identical periods seen
//   overflow_o slave->master  sticky period-counter saturation flag
//   duty_err_o slave->master  duty check failed on last measurement
//
//   WIDTH must match the WIDTH of the clk_ratio_meter it connects to.
// ----------------------------------------------------------------------------
interface clk_ratio_meter_if #(
  parameter int WIDTH = 8
);
  logic             div_i;
  logic             en_i;
  logic [WIDTH-1:0] period_o;
  logic [WIDTH-1:0] high_o;
  logic             valid_o;
  logic             locked_o;
  logic             overflow_o;
  logic             duty_err_o;

  modport master (
    output div_i, en_i,
    input  period_o, high_o, valid_o, locked_o, overflow_o, duty_err_o
  );

  modport slave (
    input  div_i, en_i,
    output period_o, high_o, valid_o, locked_o, overflow_o, duty_err_o
  );
endinterface

// File: rtl/clk_ratio_meter.sv
// ----------------------------------------------------------------------------
// clk_ratio_meter
//   Samples a slow divided clock (bus.div_i) in the clk_i domain, measures its
//   rising-edge-to-rising-edge period in clk_i cycles, pulses valid_o with each
//   new measurement and asserts locked_o after LOCK_COUNT equal periods.
//
//   Ports:
//     clk_i  measurement clock
//     rst    synchronous, active-high reset
//     bus    clk_ratio_meter_if.slave (div_i, en_i in; results out)
//
//   Optional feature, enabled by defining CLK_RATIO_DUTY_CHECK_EN:
//     high-time measurement on high_o and a duty-cycle check on duty_err_o.
//     Without the macro both outputs are tied to 0.
// ----------------------------------------------------------------------------
module clk_ratio_meter #(
  parameter int WIDTH       = 8,
  parameter int LOCK_COUNT  = 4,   // 2..15
  parameter int SYNC_STAGES = 2    // >= 2
) (
  input logic               clk_i,
  input logic               rst,
  clk_ratio_meter_if.slave  bus
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [3:0]       LOCK_CNT = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   p_q;
  logic                   s;
  logic                   rise, fall;
  logic [WIDTH-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       period_q, period_d;
  logic [3:0]             match_q, match_d;
  logic                   valid_q, valid_d;
  logic                   locked_q, locked_d;
  logic                   overflow_q, overflow_d;
  logic                   meas;   // a period measurement is taken this cycle

  // --------------------------------------------------------------------------
  // Input conditioning: synchronizer plus one history flop for edge detect.
  // NOTE: the synchronizer flops are reset along with everything else so that
  // no spurious edge is seen on the first cycles after reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst) begin
      sync_q <= '0;
      p_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.div_i};
      p_q    <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~p_q;
  assign fall = ~s & p_q;

  // --------------------------------------------------------------------------
  // State and measurement registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      period_q   <= '0;
      match_q    <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      match_q    <= match_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      overflow_q <= overflow_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic.
  // NOTE: every variable gets a default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    period_d   = period_q;
    match_d    = match_q;
    valid_d    = 1'b0;
    locked_d   = locked_q;
    overflow_d = overflow_q;
    meas       = 1'b0;

    if (!bus.en_i) begin
      // Disable wins over a coincident rise: no measurement is reported.
      state_d  = IDLE;
      locked_d = 1'b0;
      match_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d    = ARM;
          overflow_d = 1'b0;
          locked_d   = 1'b0;
        end
        ARM: begin
          if (rise) begin
            cnt_d   = CNT_ONE;
            match_d = '0;      // marks the next measurement as the first one
            state_d = MEASURE;
          end
        end
        MEASURE, LOCKED: begin
          if (rise) begin
            // A rise on the saturating cycle is still a valid measurement.
            meas     = 1'b1;
            period_d = cnt_q;
            valid_d  = 1'b1;
            cnt_d    = CNT_ONE;
            if (match_q != '0 && cnt_q == period_q)
              match_d = (match_q >= LOCK_CNT) ? LOCK_CNT : match_q + 4'd1;
            else
              match_d = 4'd1;
            locked_d = (match_d >= LOCK_CNT);
            state_d  = locked_d ? LOCKED : MEASURE;
          end else if (cnt_q == CNT_MAX) begin
            // Period too long to measure: drop it and re-arm.
            overflow_d = 1'b1;
            locked_d   = 1'b0;
            match_d    = '0;
            state_d    = ARM;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.period_o   = period_q;
  assign bus.valid_o    = valid_q;
  assign bus.locked_o   = locked_q;
  assign bus.overflow_o = overflow_q;

`ifdef CLK_RATIO_DUTY_CHECK_EN
  // --------------------------------------------------------------------------
  // High-time measurement and duty check. The high time captured on the fall
  // is published together with the period on the following rise.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] hcnt_q, hcap_q, high_q;
  logic             derr_q;
  logic [WIDTH+1:0] twice_high, period_ext, diff;
  logic             derr_d;

  always_comb begin
    twice_high = {1'b0, hcap_q, 1'b0};
    period_ext = {2'b00, cnt_q};
    diff       = (twice_high >= period_ext) ? twice_high - period_ext
                                            : period_ext - twice_high;
    // An odd period cannot split evenly, so one cycle of imbalance is allowed.
    derr_d     = (diff > {{(WIDTH+1){1'b0}}, cnt_q[0]});
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      hcnt_q <= '0;
      hcap_q <= '0;
      high_q <= '0;
      derr_q <= 1'b0;
    end else begin
      if (rise)
        hcnt_q <= CNT_ONE;
      else if (s && hcnt_q != CNT_MAX)
        hcnt_q <= hcnt_q + CNT_ONE;
      if (fall)
        hcap_q <= hcnt_q;
      if (meas) begin
        high_q <= hcap_q;
        derr_q <= derr_d;
      end
    end
  end

  assign bus.high_o     = high_q;
  assign bus.duty_err_o = derr_q;
`else
  logic unused_duty;
  assign unused_duty    = meas ^ fall;
  assign bus.high_o     = '0;
  assign bus.duty_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_clk_ratio_meter.sv
// ----------------------------------------------------------------------------
// tb_clk_ratio_meter
//   Directed bench for clk_ratio_meter. Two instances share clk_i and rst:
//   dut8 (WIDTH=8) covers reset, lock/relock, enable drop and duty checking;
//   dut4 (WIDTH=4) covers period-counter overflow. div_i changes 1 time unit
//   after a rising edge and outputs are sampled at that same point.
//   Define CLK_RATIO_DUTY_CHECK_EN for both RTL and bench to check the duty
//   feature; otherwise high_o/duty_err_o are expected to stay 0.
// ----------------------------------------------------------------------------
module tb_clk_ratio_meter;

`ifdef CLK_RATIO_DUTY_CHECK_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst   = 1'b1;

  clk_ratio_meter_if #(.WIDTH(8)) bus8 ();
  clk_ratio_meter_if #(.WIDTH(4)) bus4 ();

  clk_ratio_meter #(.WIDTH(8)) dut8 (.clk_i(clk_i), .rst(rst), .bus(bus8));
  clk_ratio_meter #(.WIDTH(4)) dut4 (.clk_i(clk_i), .rst(rst), .bus(bus4));

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Last values seen with valid_o, and valid pulse counts.
  int       nv8 = 0;
  int       nv4 = 0;
  int       per8, lock8, high8, derr8;
  int       per4;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clk_i cycle: sample outputs of the edge just passed, then drive div.
  task automatic tick(input logic d);
    @(posedge clk_i);
    #1;
    if (bus8.valid_o) begin
      nv8++;
      per8  = int'(bus8.period_o);
      lock8 = int'(bus8.locked_o);
      high8 = int'(bus8.high_o);
      derr8 = int'(bus8.duty_err_o);
    end
    if (bus4.valid_o) begin
      nv4++;
      per4 = int'(bus4.period_o);
    end
    bus8.div_i = d;
    bus4.div_i = d;
  endtask

  task automatic run_period(input int h, input int l);
    for (int i = 0; i < h + l; i++) tick(i < h);
  endtask

  initial begin
    bus8.div_i = 1'b0; bus8.en_i = 1'b0;
    bus4.div_i = 1'b0; bus4.en_i = 1'b0;

    // 1. Reset held three cycles with div toggling.
    rst = 1'b1;
    tick(1'b1); tick(1'b0); tick(1'b1);
    check("rst_period",   int'(bus8.period_o),   0);
    check("rst_high",     int'(bus8.high_o),     0);
    check("rst_valid",    int'(bus8.valid_o),    0);
    check("rst_locked",   int'(bus8.locked_o),   0);
    check("rst_overflow", int'(bus8.overflow_o), 0);
    check("rst_duty",     int'(bus8.duty_err_o), 0);
    check("rst_period4",  int'(bus4.period_o),   0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick(i[0]);
    for (int i = 0; i < 4; i++) tick(1'b0);
    check("idle_no_valid", nv8, 0);
    check("idle_locked",   int'(bus8.locked_o), 0);

    // 2. Period 6, lock on the fourth measurement.
    bus8.en_i = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0);
    nv8 = 0;
    run_period(3, 3);
    check("arm_no_valid", nv8, 0);
    run_period(3, 3);
    check("p6_first_valid", nv8, 1);
    check("p6_first_period", per8, 6);
    check("p6_first_unlocked", lock8, 0);
    run_period(3, 3);
    run_period(3, 3);
    check("p6_third_valid", nv8, 3);
    check("p6_third_unlocked", lock8, 0);
    run_period(3, 3);
    check("p6_fourth_valid", nv8, 4);
    check("p6_fourth_period", per8, 6);
    check("p6_fourth_locked", lock8, 1);

    // 3. Change to period 8 while locked.
    run_period(4, 4);
    check("p8_last6_period", per8, 6);
    check("p8_last6_locked", lock8, 1);
    run_period(4, 4);
    check("p8_first_period", per8, 8);
    check("p8_first_unlocked", lock8, 0);
    run_period(4, 4);
    run_period(4, 4);
    check("p8_third_valid", nv8, 8);
    check("p8_third_unlocked", lock8, 0);
    run_period(4, 4);
    check("p8_relock_period", per8, 8);
    check("p8_relock", lock8, 1);

    // 6. Drop en_i in the cycle the rise is detected.
    tick(1'b1); tick(1'b1); tick(1'b1);
    bus8.en_i = 1'b0;
    tick(1'b1);
    check("endrop_valid",  int'(bus8.valid_o),  0);
    check("endrop_locked", int'(bus8.locked_o), 0);
    check("endrop_period", int'(bus8.period_o), 8);
    for (int i = 0; i < 6; i++) tick(1'b0);
    check("endrop_no_valid", nv8, 9);

    // 5. Duty measurements: 6/2, 7/3, 8/4.
    bus8.en_i = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0);
    run_period(2, 4);
    run_period(3, 4);
    check("duty_p6_period", per8, 6);
    check("duty_p6_high", high8, DUTY ? 2 : 0);
    check("duty_p6_err", derr8, DUTY ? 1 : 0);
    run_period(4, 4);
    check("duty_p7_period", per8, 7);
    check("duty_p7_high", high8, DUTY ? 3 : 0);
    check("duty_p7_err", derr8, 0);
    run_period(4, 4);
    check("duty_p8_period", per8, 8);
    check("duty_p8_high", high8, DUTY ? 4 : 0);
    check("duty_p8_err", derr8, 0);
    check("duty_valid_count", nv8, 12);

    // 4. Overflow on the 4-bit instance.
    bus8.en_i = 1'b0;
    bus4.en_i = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0);
    nv4 = 0;
    tick(1'b1); tick(1'b1); tick(1'b1);
    for (int i = 0; i < 15; i++) tick(1'b0);
    check("ovf_not_yet", int'(bus4.overflow_o), 0);
    tick(1'b0);
    check("ovf_set", int'(bus4.overflow_o), 1);
    check("ovf_unlocked", int'(bus4.locked_o), 0);
    check("ovf_no_valid", nv4, 0);
    for (int i = 0; i < 4; i++) tick(1'b0);
    run_period(2, 3);
    run_period(2, 3);
    check("ovf_p5_valid", nv4, 1);
    check("ovf_p5_period", per4, 5);
    check("ovf_sticky", int'(bus4.overflow_o), 1);
    bus4.en_i = 1'b0;
    tick(1'b0); tick(1'b0);
    check("ovf_idle_hold", int'(bus4.overflow_o), 1);
    check("ovf_idle_period", int'(bus4.period_o), 5);
    bus4.en_i = 1'b1;
    tick(1'b0); tick(1'b0);
    check("ovf_cleared", int'(bus4.overflow_o), 0);

    // Reset mid-operation.
    rst = 1'b1;
    tick(1'b0);
    check("midrst_period8", int'(bus8.period_o), 0);
    check("midrst_period4", int'(bus4.period_o), 0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
